// File: rtl/data_bus_pkg.sv
// Shared constants for the data-side bus: peripheral address map, RV32I
// load/store funct3 codes, memory_control field layout and UART FSM states.
package data_bus_pkg;

  localparam logic [31:0] PERIPH_BASE      = 32'h8000_0000;
  localparam logic [31:0] ADDR_UART_DATA   = PERIPH_BASE + 32'h0;
  localparam logic [31:0] ADDR_UART_STATUS = PERIPH_BASE + 32'h4;
  localparam logic [31:0] ADDR_CYCLES      = PERIPH_BASE + 32'h8;
  localparam logic [31:0] ADDR_LEDS        = PERIPH_BASE + 32'hC;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam int MC_WE     = 3;
  localparam int MC_F3_MSB = 2;
  localparam int MC_F3_LSB = 0;

  typedef enum logic [1:0] {
    UART_IDLE  = 2'd0,
    UART_START = 2'd1,
    UART_BITS  = 2'd2,
    UART_STOP  = 2'd3
  } uart_state_t;

endpackage

// File: rtl/data_bus_uart_tx.sv
// 8N1 serial transmitter, LSB first. A start request is only honoured in IDLE;
// tx and busy are registered so they change on the edge after the request.
module uart_tx
  import data_bus_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       busy,
  output logic       tx
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  uart_state_t   state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          period_done;

  assign period_done = (cnt == LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= UART_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      busy    <= 1'b0;
      tx      <= 1'b1;
    end else begin
      case (state)
        UART_IDLE: begin
          if (start) begin
            state <= UART_START;
            shreg <= data;
            cnt   <= '0;
            busy  <= 1'b1;
            tx    <= 1'b0;
          end
        end
        UART_START: begin
          if (period_done) begin
            state   <= UART_BITS;
            cnt     <= '0;
            bit_idx <= '0;
            tx      <= shreg[0];
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        UART_BITS: begin
          if (period_done) begin
            cnt <= '0;
            if (bit_idx == 3'd7) begin
              state <= UART_STOP;
              tx    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shreg[bit_idx + 3'd1];
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        UART_STOP: begin
          // busy stays high through the final stop cycle, so a write landing
          // on that same edge is still rejected.
          if (period_done) begin
            state <= UART_IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= UART_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/data_bus.sv
// Data-side memory block for the RV32I core: byte-lane word RAM with
// combinational loads, plus LED register, cycle counter and UART transmitter.
module data_bus
  import data_bus_pkg::*;
#(
  parameter int RAM_WORDS    = 1024,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  memory_control,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic [7:0]  leds,
  output logic        uart_tx
);

  localparam int AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;

  logic [31:0]   ram [RAM_WORDS];
  logic [31:0]   cycles;
  logic          uart_busy;
  logic          uart_start;
  logic          we;
  logic [2:0]    f3;
  logic          ram_hit;
  logic [AW-1:0] ram_idx;
  logic          hit_uart_data, hit_status, hit_cycles, hit_leds;
  logic [3:0]    lane_en;
  logic [31:0]   lane_data;
  logic          store_ok;
  logic [31:0]   word;

  assign we      = memory_control[MC_WE];
  assign f3      = memory_control[MC_F3_MSB:MC_F3_LSB];
  assign ram_hit = (address < 32'(4 * RAM_WORDS));
  assign ram_idx = address[AW+1:2];

  // Peripherals decode on the word address so sub-word loads pick lanes.
  assign hit_uart_data = (address[31:2] == ADDR_UART_DATA[31:2]);
  assign hit_status    = (address[31:2] == ADDR_UART_STATUS[31:2]);
  assign hit_cycles    = (address[31:2] == ADDR_CYCLES[31:2]);
  assign hit_leds      = (address[31:2] == ADDR_LEDS[31:2]);

  function automatic logic [31:0] load_extend(input logic [31:0] w,
                                              input logic [2:0]  fn,
                                              input logic [1:0]  lo);
    logic [31:0] shifted;
    logic [7:0]  b;
    logic [15:0] h;
    shifted = w >> {lo, 3'b000};
    b       = shifted[7:0];
    h       = lo[1] ? w[31:16] : w[15:0];
    case (fn)
      F3_LB:   return {{24{b[7]}}, b};
      F3_LH:   return {{16{h[15]}}, h};
      F3_LW:   return w;
      F3_LBU:  return {24'b0, b};
      F3_LHU:  return {16'b0, h};
      default: return 32'b0;
    endcase
  endfunction

  always_comb begin
    lane_en   = 4'b0000;
    lane_data = write_data;
    case (f3)
      F3_SB: begin
        lane_en   = 4'b0001 << address[1:0];
        lane_data = {4{write_data[7:0]}};
      end
      F3_SH: begin
        lane_en   = address[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{write_data[15:0]}};
      end
      F3_SW:   lane_en = 4'b1111;
      default: lane_en = 4'b0000;
    endcase
  end

  assign store_ok   = we && (lane_en != 4'b0000);
  assign uart_start = store_ok && hit_uart_data;

  always_comb begin
    word = 32'b0;
    if (ram_hit)         word = ram[ram_idx];
    else if (hit_status) word = {31'b0, uart_busy};
    else if (hit_cycles) word = cycles;
    else if (hit_leds)   word = {24'b0, leds};
    read_data = load_extend(word, f3, address[1:0]);
  end

  always_ff @(posedge clock) begin
    if (store_ok && ram_hit) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_en[i]) ram[ram_idx][8*i +: 8] <= lane_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cycles <= '0;
      leds   <= '0;
    end else begin
      cycles <= cycles + 32'd1;
      if (store_ok && hit_leds) leds <= write_data[7:0];
    end
  end

  uart_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart (
    .clock(clock),
    .reset(reset),
    .start(uart_start),
    .data (write_data[7:0]),
    .busy (uart_busy),
    .tx   (uart_tx)
  );

endmodule

// File: tb/tb_data_bus.sv
// Scoreboard bench for data_bus: stimulus pushes expectations from a byte-level
// memory/peripheral model; a negedge monitor pops and compares them.
module tb_data_bus;

  localparam int RW  = 64;
  localparam int CPB = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  memory_control = 4'b0011;
  logic [31:0] address = '0;
  logic [31:0] write_data = '0;
  logic [31:0] read_data;
  logic [7:0]  leds;
  logic        uart_tx;

  data_bus #(.RAM_WORDS(RW), .CLKS_PER_BIT(CPB)) dut (
    .clock(clock), .reset(reset), .memory_control(memory_control),
    .address(address), .write_data(write_data), .read_data(read_data),
    .leds(leds), .uart_tx(uart_tx)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          kind;
    logic [31:0] exp;
    string       name;
  } chk_t;

  chk_t        sbq[$];
  int          total = 0;
  int          bad = 0;
  logic [7:0]  mem_m [256];
  logic [7:0]  leds_m = 8'h00;
  int          edges = 0;
  bit          in_reset = 1'b1;

  always @(negedge clock) begin
    chk_t        c;
    logic [31:0] act;
    while (sbq.size() > 0) begin
      c = sbq.pop_front();
      case (c.kind)
        0:       act = read_data;
        1:       act = {31'b0, uart_tx};
        default: act = {24'b0, leds};
      endcase
      total++;
      if (act !== c.exp) begin
        bad++;
        $display("FAIL %s got=%h want=%h", c.name, act, c.exp);
      end
    end
  end

  task automatic push(input int kind, input logic [31:0] exp, input string name);
    chk_t c;
    c.kind = kind; c.exp = exp; c.name = name;
    sbq.push_back(c);
  endtask

  task automatic step();
    @(posedge clock);
    edges++;
    #1;
  endtask

  function automatic logic [7:0] get_byte(input logic [31:0] a);
    logic [31:0] w;
    w = 32'b0;
    if (a < 32'(4 * RW)) return mem_m[a[7:0]];
    case ({a[31:2], 2'b00})
      32'h8000_0008: w = in_reset ? 32'd0 : 32'(edges);
      32'h8000_000C: w = {24'b0, leds_m};
      default:       w = 32'b0;
    endcase
    return 8'(w >> (8 * a[1:0]));
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] f3);
    logic [31:0] ah, aw;
    logic [7:0]  b;
    logic [15:0] h;
    ah = a & ~32'd1;
    aw = a & ~32'd3;
    b  = get_byte(a);
    h  = {get_byte(ah + 1), get_byte(ah)};
    case (f3)
      3'd0:    return {{24{b[7]}}, b};
      3'd1:    return {{16{h[15]}}, h};
      3'd2:    return {get_byte(aw + 3), get_byte(aw + 2), get_byte(aw + 1), get_byte(aw)};
      3'd4:    return {24'b0, b};
      3'd5:    return {16'b0, h};
      default: return 32'b0;
    endcase
  endfunction

  task automatic model_store(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] ah, aw;
    ah = a & ~32'd1;
    aw = a & ~32'd3;
    if (f3 > 3'd2) return;
    if (a < 32'(4 * RW)) begin
      case (f3)
        3'd0: mem_m[a[7:0]] = wd[7:0];
        3'd1: begin mem_m[ah[7:0]] = wd[7:0]; mem_m[ah[7:0] + 8'd1] = wd[15:8]; end
        default: for (int i = 0; i < 4; i++) mem_m[aw[7:0] + 8'(i)] = wd[8*i +: 8];
      endcase
    end else if (aw == 32'h8000_000C) begin
      leds_m = wd[7:0];
    end
  endtask

  task automatic do_op(input bit we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input bit chk, input string name);
    memory_control = {we, f3};
    address        = a;
    write_data     = wd;
    if (chk) push(0, model_load(a, f3), name);
    push(2, {24'b0, leds_m}, "leds_out");
    push(1, 32'd1, "tx_idle");
    step();
    if (we) model_store(a, f3, wd);
  endtask

  task automatic do_lit(input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] exp, input string name);
    memory_control = {1'b0, f3};
    address        = a;
    push(0, exp, name);
    step();
  endtask

  function automatic logic fbit(input logic [7:0] d, input int k);
    int n;
    n = k / CPB;
    if (n == 0) return 1'b0;
    if (n <= 8) return d[n-1];
    return 1'b1;
  endfunction

  task automatic uart_frame(input logic [7:0] d, input bit second);
    memory_control = 4'b1010;
    address        = 32'h8000_0000;
    write_data     = {24'b0, d};
    push(0, 32'd0, "uart_data_read");
    push(1, 32'd1, "tx_before");
    step();
    for (int k = 0; k < 10 * CPB; k++) begin
      if (second && k == 10) begin
        memory_control = 4'b1010;
        address        = 32'h8000_0000;
        write_data     = 32'h0000_00AA;
      end else begin
        memory_control = 4'b0010;
        address        = 32'h8000_0004;
        push(0, 32'd1, "status_busy");
      end
      push(1, {31'b0, fbit(d, k)}, "tx_bit");
      step();
    end
    memory_control = 4'b0010;
    address        = 32'h8000_0004;
    for (int k = 0; k < 3 * CPB; k++) begin
      push(0, 32'd0, "status_idle");
      push(1, 32'd1, "tx_after");
      step();
    end
  endtask

  task automatic reset_mid_frame();
    memory_control = 4'b1010;
    address        = 32'h8000_0000;
    write_data     = 32'h0000_003C;
    step();
    memory_control = 4'b0011;
    for (int k = 0; k < 12; k++) begin
      push(1, {31'b0, fbit(8'h3C, k)}, "tx_frame_pre_reset");
      step();
    end
    reset    = 1'b0;
    in_reset = 1'b1;
    leds_m   = 8'h00;
    #1;
    memory_control = 4'b0010;
    address        = 32'h8000_0004;
    push(0, 32'd0, "status_in_reset");
    push(1, 32'd1, "tx_in_reset");
    push(2, 32'd0, "leds_in_reset");
    step();
    address = 32'h8000_0008;
    push(0, 32'd0, "cycles_in_reset");
    step();
    reset    = 1'b1;
    in_reset = 1'b0;
    edges    = 0;
    push(0, 32'd0, "cycles_at_release");
    repeat (3) step();
    push(0, 32'd3, "cycles_3");
    repeat (5) step();
    push(0, 32'd8, "cycles_8");
    push(1, 32'd1, "tx_after_reset");
    step();
    uart_frame(8'hC3, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a;
    logic [2:0]  f3;
    bit          we;
    logic [31:0] pa [6];
    pa[0] = 32'h8000_0004; pa[1] = 32'h8000_0008; pa[2] = 32'h8000_000C;
    pa[3] = 32'h4000_0000; pa[4] = 32'h8000_0010; pa[5] = 32'h0000_0400;
    for (int i = 0; i < 256; i++) mem_m[i] = 8'h00;

    #2;
    memory_control = 4'b0010;
    address        = 32'h8000_0008;
    push(0, 32'd0, "rst_cycles");
    push(1, 32'd1, "rst_tx");
    push(2, 32'd0, "rst_leds");
    step();
    address = 32'h8000_0004;
    push(0, 32'd0, "rst_status");
    step();
    reset    = 1'b1;
    in_reset = 1'b0;
    edges    = 0;

    for (int i = 0; i < RW; i++) do_op(1'b1, 3'd2, 32'(i * 4), 32'd0, 1'b0, "zero_fill");

    do_op(1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF, 1'b1, "sw_10_old");
    do_lit(3'd2, 32'h10, 32'hDEAD_BEEF, "lw_10");
    do_lit(3'd4, 32'h13, 32'h0000_00DE, "lbu_13");
    do_lit(3'd1, 32'h12, 32'hFFFF_DEAD, "lh_12");
    do_lit(3'd5, 32'h10, 32'h0000_BEEF, "lhu_10");
    do_op(1'b1, 3'd0, 32'h22, 32'h0000_0080, 1'b1, "sb_22_old");
    do_lit(3'd0, 32'h22, 32'hFFFF_FF80, "lb_22");
    do_lit(3'd4, 32'h22, 32'h0000_0080, "lbu_22");
    do_lit(3'd2, 32'h20, 32'h0080_0000, "lw_20");
    do_op(1'b1, 3'd2, 32'h30, 32'h1122_3344, 1'b1, "rdw_old");
    do_lit(3'd2, 32'h30, 32'h1122_3344, "rdw_new");

    do_op(1'b1, 3'd2, 32'h8000_000C, 32'h0000_01A5, 1'b1, "sw_leds");
    total++;
    if (leds !== 8'hA5) begin
      bad++;
      $display("FAIL leds_direct got=%h want=a5", leds);
    end
    push(2, 32'h0000_00A5, "leds_a5");
    do_lit(3'd2, 32'h8000_000C, 32'h0000_00A5, "lw_leds");
    do_op(1'b1, 3'd2, 32'h4000_0000, 32'h1234_5678, 1'b1, "sw_unmapped");
    do_lit(3'd2, 32'h4000_0000, 32'h0000_0000, "lw_unmapped");
    push(2, 32'h0000_00A5, "leds_kept");
    do_lit(3'd2, 32'h8000_000C, 32'h0000_00A5, "lw_leds_kept");

    uart_frame(8'h55, 1'b1);

    for (int i = 0; i < 300; i++) begin
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 99) < 75) begin
        a = 32'($urandom_range(0, 4 * RW - 1));
      end else begin
        a = pa[$urandom_range(0, 5)];
        if (!we) a = a | 32'($urandom_range(0, 3));
      end
      do_op(we, f3, a, $urandom, 1'b1, "rand_op");
    end

    reset_mid_frame();

    memory_control = 4'b0011;
    step();
    step();
    total++;
    if (uart_tx !== 1'b1) begin
      bad++;
      $display("FAIL tx_final got=%b want=1", uart_tx);
    end
    if (bad != 0) $display("FAIL total=%0d bad=%0d", total, bad);
    else          $display("PASS total=%0d", total);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_bus.md
Name: data_bus

Overview:
- Data-side memory and peripheral block directly downstream of the RV32I core.
- Consumes the core's memory_control, ALU_result (as address) and write_data; returns read_data in the same cycle.
- Contains word RAM with byte-lane writes, load size/sign extension, and memory-mapped peripherals: LED register, free-running cycle counter, UART transmitter.

Parameters:
- RAM_WORDS, 1024, RAM depth in 32-bit words; RAM occupies 0x0000_0000 to 4*RAM_WORDS-1.
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200).

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- memory_control  in  4  [3]=write enable, [2:0]=RV32I funct3 (size/sign)
- address  in  32  byte address (core ALU_result)
- write_data  in  32  store data, right-aligned
- read_data  out  32  load result, combinational
- leds  out  8  LED register
- uart_tx  out  1  serial output, idle high

Behaviour:
- Reset (reset=0, async): leds=0, uart_tx=1, UART state IDLE, cycle counter=0. RAM contents are not reset.
- Address map:
  - RAM: address < 4*RAM_WORDS.
  - 0x8000_0000 UART_DATA: write only.
  - 0x8000_0004 UART_STATUS: bit0=busy, others 0.
  - 0x8000_0008 CYCLES: read only.
  - 0x8000_000C LEDS: read/write, bits[7:0].
  - Any other address: reads return 0; writes are dropped.
- Alignment: word access ignores address[1:0]; halfword access ignores address[0]. No misalignment trap.
- Loads: combinational from address and memory_control, zero added latency. The core samples read_data in the same cycle.
  - funct3 000 LB: selected byte, sign-extended.
  - 001 LH: selected half, sign-extended.
  - 010 LW: full word.
  - 100 LBU / 101 LHU: zero-extended.
  - Other funct3: returns 0.
- Stores: when memory_control[3]=1, write on rising edge.
  - 000 SB: one byte lane from write_data[7:0].
  - 001 SH: two lanes from write_data[15:0].
  - 010 SW: all four lanes.
  - Other funct3: no write.
- Read-during-write to the same RAM word: read_data shows the old contents. The new value is visible next cycle.
- Peripheral stores:
  - LEDS takes write_data[7:0] for any store size.
  - UART_DATA takes write_data[7:0] for any store size.
- Loads from peripherals: the register value is placed in the word, then the same lane select and extension rules are applied as for RAM.
- Cycle counter: 32-bit, increments every cycle, wraps 0xFFFF_FFFF to 0. CYCLES and STATUS writes are ignored.
- UART TX, 8N1, LSB first. States:
  - IDLE -> START: on a UART_DATA write while IDLE; latch the byte.
  - START: 1 bit period, uart_tx=0.
  - DATA: 8 bit periods, bit index 0..7.
  - STOP: 1 bit period, uart_tx=1.
  - STOP -> IDLE.
- Each bit period is exactly CLKS_PER_BIT cycles. First start-bit cycle is the cycle after the write edge.
- busy=1 in every state except IDLE.
- UART_DATA write while busy: dropped silently. The frame in progress is unaffected.
- A UART_DATA write in the same cycle that STOP completes is dropped; busy is still 1 in that cycle.
- Reset mid-frame: uart_tx returns to 1 immediately and the frame is abandoned.

Decomposition:
- Shared package holds:
  - address constants (UART_DATA, UART_STATUS, CYCLES, LEDS, peripheral base 0x8000_0000);
  - funct3 codes LB/LH/LW/LBU/LHU/SB/SH/SW;
  - memory_control field positions;
  - UART state encodings.
- One sub-module: uart_tx (clock, reset, start, data[7:0], busy, tx), parameterised by CLKS_PER_BIT.
- Address decode, lane logic and the counter stay in data_bus.

Test Plan:
- SW 0xDEADBEEF to 0x10, then LW 0x10 -> 0xDEADBEEF. LBU 0x13 -> 0x000000DE. LH 0x12 -> 0xFFFFDEAD. LHU 0x10 -> 0x0000BEEF.
- SB 0x80 to 0x22 over prior word 0: LB 0x22 -> 0xFFFFFF80; LBU 0x22 -> 0x00000080; LW 0x20 -> 0x00800000.
- With CLKS_PER_BIT=4:
  - SW 0x55 to UART_DATA -> uart_tx low for 4 cycles, then bits 1,0,1,0,1,0,1,0 at 4 cycles each, then high for 4.
  - STATUS reads 1 throughout the 40 cycles, then 0.
  - A second write at cycle 10 is dropped: no second frame.
- Assert reset at cycle 12 of a frame -> uart_tx=1 and STATUS=0 asynchronously. A new write after release sends a full frame.
- Read CYCLES twice, 5 cycles apart -> difference 5. After reset release, first read equals the cycles elapsed since release.
- SW 0x1A5 to LEDS -> leds=0xA5, LW LEDS -> 0x000000A5. SW to 0x4000_0000 -> no state change; LW 0x4000_0000 -> 0.
